// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Shares one memory-side bus between the I-cache and D-cache memory ports.
// Only one transaction is in flight at a time. D has fixed priority over I.
// A starvation guard forces an I grant after STARVE_LIMIT consecutive D grants
// during which I was waiting.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   i_* (a/din/strobe/rw/wen/size -> dout/ready)  I-cache master port
//   d_* (same set)                                D-cache master port
//   m_* (a/din/strobe/rw/wen/size <- dout/ready)  memory bridge port
//   grant                     debug: 01 = I owns bus, 10 = D owns bus, 00 = idle
module mem_bus_arbiter #(
  parameter int unsigned A_WIDTH      = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [A_WIDTH-1:0] i_a,
  input  logic [31:0]        i_din,
  output logic [31:0]        i_dout,
  input  logic               i_strobe,
  input  logic               i_rw,
  input  logic [3:0]         i_wen,
  input  logic [1:0]         i_size,
  output logic               i_ready,
  input  logic [A_WIDTH-1:0] d_a,
  input  logic [31:0]        d_din,
  output logic [31:0]        d_dout,
  input  logic               d_strobe,
  input  logic               d_rw,
  input  logic [3:0]         d_wen,
  input  logic [1:0]         d_size,
  output logic               d_ready,
  output logic [A_WIDTH-1:0] m_a,
  output logic [31:0]        m_din,
  input  logic [31:0]        m_dout,
  output logic               m_strobe,
  output logic               m_rw,
  output logic [3:0]         m_wen,
  output logic [1:0]         m_size,
  input  logic               m_ready,
  output logic [1:0]         grant
);

  localparam int unsigned CNT_W = (STARVE_LIMIT == 0) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY_I = 2'd1;
  localparam logic [1:0] S_BUSY_D = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             w_i_starved;

  // I has waited through the maximum number of D grants; a limit of 0 never starves.
  assign w_i_starved = (STARVE_LIMIT != 0) && (r_starve_cnt == CNT_MAX);

  // State and starvation counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Arbitration in IDLE; completion on m_ready. Always returning to IDLE
  // gives the finishing master one cycle to drop its strobe.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve_cnt;
    case (r_state)
      S_IDLE: begin
        if (d_strobe && !(i_strobe && w_i_starved)) begin
          w_state_nxt = S_BUSY_D;
          if (i_strobe && (r_starve_cnt != CNT_MAX)) begin
            w_starve_nxt = r_starve_cnt + CNT_W'(1);
          end
        end else if (i_strobe) begin
          w_state_nxt  = S_BUSY_I;
          w_starve_nxt = '0;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        if (m_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Bus mux: the owner's live request drives the memory side; ready is
  // routed back only to the owner.
  always_comb begin
    m_a      = '0;
    m_din    = '0;
    m_strobe = 1'b0;
    m_rw     = 1'b0;
    m_wen    = '0;
    m_size   = '0;
    i_ready  = 1'b0;
    d_ready  = 1'b0;
    grant    = 2'b00;
    case (r_state)
      S_BUSY_I: begin
        m_a      = i_a;
        m_din    = i_din;
        m_strobe = 1'b1;
        m_rw     = i_rw;
        m_wen    = i_wen;
        m_size   = i_size;
        i_ready  = m_ready;
        grant    = 2'b01;
      end
      S_BUSY_D: begin
        m_a      = d_a;
        m_din    = d_din;
        m_strobe = 1'b1;
        m_rw     = d_rw;
        m_wen    = d_wen;
        m_size   = d_size;
        d_ready  = m_ready;
        grant    = 2'b10;
      end
      default: begin
      end
    endcase
  end

  // Read data is broadcast; each master qualifies it with its own ready.
  assign i_dout = m_dout;
  assign d_dout = m_dout;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level ownership model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int SL = 2;
  localparam int OWN_NONE = 0;
  localparam int OWN_I = 1;
  localparam int OWN_D = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] i_a, d_a, m_a;
  logic [31:0]   i_din, i_dout, d_din, d_dout, m_din, m_dout;
  logic          i_strobe, i_rw, i_ready, d_strobe, d_rw, d_ready;
  logic [3:0]    i_wen, d_wen, m_wen;
  logic [1:0]    i_size, d_size, m_size, grant;
  logic          m_strobe, m_rw, m_ready;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: who owns the bus, whether the bus must rest one cycle,
  // and how many D grants I has sat through.
  int owner = OWN_NONE;
  int d_wins = 0;

  int grant_log[$];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.A_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .i_a(i_a), .i_din(i_din), .i_dout(i_dout), .i_strobe(i_strobe), .i_rw(i_rw),
    .i_wen(i_wen), .i_size(i_size), .i_ready(i_ready),
    .d_a(d_a), .d_din(d_din), .d_dout(d_dout), .d_strobe(d_strobe), .d_rw(d_rw),
    .d_wen(d_wen), .d_size(d_size), .d_ready(d_ready),
    .m_a(m_a), .m_din(m_din), .m_dout(m_dout), .m_strobe(m_strobe), .m_rw(m_rw),
    .m_wen(m_wen), .m_size(m_size), .m_ready(m_ready),
    .grant(grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every DUT output with what the model's current owner implies.
  task automatic check_all();
    logic [31:0] ea, edin;
    logic        es, erw, eir, edr;
    logic [3:0]  ewen;
    logic [1:0]  esz, egr;
    ea = '0; edin = '0; es = 1'b0; erw = 1'b0; ewen = '0; esz = '0;
    egr = 2'b00; eir = 1'b0; edr = 1'b0;
    if (owner == OWN_I) begin
      ea = i_a; edin = i_din; es = 1'b1; erw = i_rw; ewen = i_wen; esz = i_size;
      egr = 2'b01; eir = m_ready;
    end else if (owner == OWN_D) begin
      ea = d_a; edin = d_din; es = 1'b1; erw = d_rw; ewen = d_wen; esz = d_size;
      egr = 2'b10; edr = m_ready;
    end
    chk("m_strobe", 32'(m_strobe), 32'(es));
    chk("m_a", m_a, ea);
    chk("m_din", m_din, edin);
    chk("m_rw", 32'(m_rw), 32'(erw));
    chk("m_wen", 32'(m_wen), 32'(ewen));
    chk("m_size", 32'(m_size), 32'(esz));
    chk("grant", 32'(grant), 32'(egr));
    chk("i_ready", 32'(i_ready), 32'(eir));
    chk("d_ready", 32'(d_ready), 32'(edr));
    chk("i_dout", i_dout, m_dout);
    chk("d_dout", d_dout, m_dout);
  endtask

  // Advance the model by one clock using the inputs present at the edge.
  task automatic model_step();
    if (rst) begin
      owner = OWN_NONE;
      d_wins = 0;
    end else if (owner != OWN_NONE) begin
      if (m_ready) owner = OWN_NONE;
    end else begin
      if (d_strobe && !(i_strobe && SL != 0 && d_wins >= SL)) begin
        owner = OWN_D;
        if (i_strobe) d_wins = (d_wins + 1 > SL) ? SL : d_wins + 1;
      end else if (i_strobe) begin
        owner = OWN_I;
        d_wins = 0;
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic idle_inputs();
    i_a = '0; i_din = '0; i_strobe = 1'b0; i_rw = 1'b0; i_wen = '0; i_size = '0;
    d_a = '0; d_din = '0; d_strobe = 1'b0; d_rw = 1'b0; d_wen = '0; d_size = '0;
    m_dout = '0; m_ready = 1'b0;
  endtask

  int exp_order[6] = '{2, 2, 1, 2, 2, 1};

  initial begin
    rst = 1'b1;
    idle_inputs();
    tick();
    settle();
    chk("rst_m_strobe", 32'(m_strobe), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_i_ready", 32'(i_ready), 32'h0);
    chk("rst_d_ready", 32'(d_ready), 32'h0);
    tick();
    rst = 1'b0;

    // Lone I read.
    i_strobe = 1'b1; i_a = 32'h1FC0_0000;
    settle(); chk("t1_c0_grant", 32'(grant), 32'h0); tick();
    settle();
    chk("t1_c1_strobe", 32'(m_strobe), 32'h1);
    chk("t1_c1_m_a", m_a, 32'h1FC0_0000);
    chk("t1_c1_grant", 32'(grant), 32'h1);
    tick();
    cyc();
    m_ready = 1'b1; m_dout = 32'hDEAD_BEEF;
    settle();
    chk("t1_c3_i_ready", 32'(i_ready), 32'h1);
    chk("t1_c3_i_dout", i_dout, 32'hDEAD_BEEF);
    chk("t1_c3_d_ready", 32'(d_ready), 32'h0);
    tick();
    i_strobe = 1'b0; m_ready = 1'b0;
    settle(); chk("t1_c4_grant", 32'(grant), 32'h0); tick();

    // Simultaneous requests: D first, then I after one idle cycle.
    i_strobe = 1'b1; i_a = 32'h0000_0040; d_strobe = 1'b1; d_a = 32'h0000_0080;
    cyc();
    settle(); chk("t2_c1_grant", 32'(grant), 32'h2); tick();
    m_ready = 1'b1;
    settle();
    chk("t2_c2_d_ready", 32'(d_ready), 32'h1);
    chk("t2_c2_i_ready", 32'(i_ready), 32'h0);
    tick();
    d_strobe = 1'b0; m_ready = 1'b0;
    settle(); chk("t2_c3_grant", 32'(grant), 32'h0); tick();
    settle(); chk("t2_c4_grant", 32'(grant), 32'h1); tick();
    m_ready = 1'b1;
    settle(); chk("t2_c5_i_ready", 32'(i_ready), 32'h1); tick();
    i_strobe = 1'b0; m_ready = 1'b0;
    cyc();

    // D write fields pass through.
    d_strobe = 1'b1; d_rw = 1'b1; d_wen = 4'b0011; d_size = 2'b01;
    d_din = 32'h0000_ABCD; d_a = 32'h0000_1004;
    cyc();
    settle();
    chk("t4_m_rw", 32'(m_rw), 32'h1);
    chk("t4_m_wen", 32'(m_wen), 32'h3);
    chk("t4_m_size", 32'(m_size), 32'h1);
    chk("t4_m_din", m_din, 32'h0000_ABCD);
    chk("t4_m_a", m_a, 32'h0000_1004);
    chk("t4_grant", 32'(grant), 32'h2);
    tick();
    m_ready = 1'b1;
    cyc();
    idle_inputs();
    cyc();

    // Reset during BUSY_D (with I waiting, so the starve count is nonzero).
    i_strobe = 1'b1; d_strobe = 1'b1;
    cyc();
    settle(); chk("t5_busy_grant", 32'(grant), 32'h2); tick();
    rst = 1'b1;
    cyc();
    rst = 1'b0; i_strobe = 1'b0; d_strobe = 1'b0;
    settle();
    chk("t5_m_strobe", 32'(m_strobe), 32'h0);
    chk("t5_d_ready", 32'(d_ready), 32'h0);
    chk("t5_grant", 32'(grant), 32'h0);
    tick();

    // m_ready in IDLE is ignored.
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t6_i_ready", 32'(i_ready), 32'h0);
      chk("t6_d_ready", 32'(d_ready), 32'h0);
      chk("t6_grant", 32'(grant), 32'h0);
      tick();
    end

    // Starvation guard: both held, memory always ready. The reset above
    // must have cleared the count, so the pattern starts D,D,I.
    i_strobe = 1'b1; d_strobe = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 14; k++) begin
      settle();
      if (grant != 2'b00) grant_log.push_back(int'(grant));
      tick();
    end
    chk("t3_grant_count", 32'(grant_log.size() >= 6), 32'h1);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_order_%0d", k),
          (k < grant_log.size()) ? 32'(grant_log[k]) : 32'hFFFF_FFFF,
          32'(exp_order[k]));
    end
    idle_inputs();
    cyc();

    // Random traffic; the owning master holds its request until ready.
    for (int k = 0; k < 600; k++) begin
      if (owner != OWN_I) begin
        i_strobe = ($urandom_range(0, 2) != 0);
        i_a = $urandom(); i_din = $urandom(); i_rw = 1'($urandom());
        i_wen = 4'($urandom()); i_size = 2'($urandom());
      end
      if (owner != OWN_D) begin
        d_strobe = ($urandom_range(0, 2) != 0);
        d_a = $urandom(); d_din = $urandom(); d_rw = 1'($urandom());
        d_wen = 4'($urandom()); d_size = 2'($urandom());
      end
      m_ready = ($urandom_range(0, 2) == 0);
      m_dout = $urandom();
      rst = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
